mips_lite_cpu: RTL and testbench

- Single-cycle 32-bit MIPS-subset processor core.
- Fetches from an external combinational instruction port.
- Executes one instruction per clock.
- Drives a separate data-memory port; the external memory model performs reads combinationally and writes on the rising clock edge.
- Sits between the bench clock/reset and the unified instruction/data memory model.

---
 rtl/mips_lite_cpu.sv | 112 +++++++++++
 tb/tb_mips_lite_cpu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_lite_cpu.sv
// mips_lite_cpu: single-cycle 32-bit MIPS-subset core with combinational instruction/data ports.
// Define HALT_INSN_EN to decode 32'hFC00_0000 as HALT and expose the halted output.
module mips_lite_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        pc_reset,
   input  logic        pc_enable,
   input  logic [31:0] instr,
   input  logic [31:0] data_out,
   output logic [31:0] data_in,
   output logic [31:0] inst_addr,
   output logic [31:0] data_addr,
   output logic        mem_read_ctrlsig,
   output logic        mem_write_ctrlsig
`ifdef HALT_INSN_EN
   ,
   output logic        halted
`endif
);
   logic [31:0] pc, a, b, sext, zext, pc4, alu, wdata, jt, next_pc;
   logic [31:0] rf [32];
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh, wreg;
   logic        we, rd_en, wr_en, take_br, take_j, run, live;
   assign op   = instr[31:26];
   assign rs   = instr[25:21];
   assign rt   = instr[20:16];
   assign rd   = instr[15:11];
   assign sh   = instr[10:6];
   assign fn   = instr[5:0];
   assign a    = rf[rs];
   assign b    = rf[rt];
   assign sext = {{16{instr[15]}}, instr[15:0]};
   assign zext = {16'h0, instr[15:0]};
   assign pc4  = pc + 32'd4;
   always_comb begin
      alu = '0;
      wreg = rt;
      we = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b0;
      take_br = 1'b0;
      take_j = 1'b0;
      jt = {pc4[31:28], instr[25:0], 2'b00};
      case (op)
         6'h00: begin
            wreg = rd;
            we = 1'b1;
            case (fn)
               6'h20, 6'h21: alu = a + b;
               6'h22, 6'h23: alu = a - b;
               6'h24: alu = a & b;
               6'h25: alu = a | b;
               6'h26: alu = a ^ b;
               6'h27: alu = ~(a | b);
               6'h2A: alu = {31'b0, $signed(a) < $signed(b)};
               6'h2B: alu = {31'b0, a < b};
               6'h00: alu = b << sh;
               6'h02: alu = b >> sh;
               6'h03: alu = $signed(b) >>> sh;
               6'h08: begin
                  we = 1'b0;
                  take_j = 1'b1;
                  jt = a;
               end
               default: we = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin alu = a + sext; we = 1'b1; end
         6'h0A: begin alu = {31'b0, $signed(a) < $signed(sext)}; we = 1'b1; end
         6'h0C: begin alu = a & zext; we = 1'b1; end
         6'h0D: begin alu = a | zext; we = 1'b1; end
         6'h0E: begin alu = a ^ zext; we = 1'b1; end
         6'h0F: begin alu = {instr[15:0], 16'h0}; we = 1'b1; end
         6'h23: begin alu = a + sext; we = 1'b1; rd_en = 1'b1; end
         6'h2B: begin alu = a + sext; wr_en = 1'b1; end
         6'h04: take_br = a == b;
         6'h05: take_br = a != b;
         6'h02: take_j = 1'b1;
         6'h03: begin take_j = 1'b1; alu = pc4; wreg = 5'd31; we = 1'b1; end
         default: ;
      endcase
   end
   assign wdata   = rd_en ? data_out : alu;
   assign next_pc = take_br ? pc4 + (sext << 2) : take_j ? jt : pc4;
`ifdef HALT_INSN_EN
   logic halt_q, halt_now;
   assign halt_now = instr == 32'hFC00_0000;
   assign halted   = halt_q | halt_now;
   assign live     = ~halted;
   always_ff @(posedge clk or posedge pc_reset)
      if (pc_reset) halt_q <= 1'b0;
      else if (pc_enable && halt_now) halt_q <= 1'b1;
`else
   assign live = 1'b1;
`endif
   assign run               = pc_enable & live;
   assign inst_addr         = pc;
   assign data_addr         = alu;
   assign data_in           = b;
   assign mem_read_ctrlsig  = rd_en & live & ~pc_reset;
   assign mem_write_ctrlsig = wr_en & run & ~pc_reset;
   always_ff @(posedge clk or posedge pc_reset)
      if (pc_reset) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (run) begin
         pc <= next_pc;
         if (we && wreg != 5'd0) rf[wreg] <= wdata;
      end
endmodule

// File: tb/tb_mips_lite_cpu.sv
// tb_mips_lite_cpu: directed and random programs checked against an instruction-level model.
module tb_mips_lite_cpu;
   logic        clk = 1'b0, pc_reset = 1'b0, pc_enable = 1'b0;
   logic [31:0] instr, data_out, data_in, inst_addr, data_addr;
   logic        mem_read_ctrlsig, mem_write_ctrlsig;
`ifdef HALT_INSN_EN
   logic        halted;
`endif
   logic [31:0] mem [0:255];
   logic [31:0] mm [0:255];
   logic [31:0] mr [0:31];
   logic [31:0] mpc, v;
   bit          mhalt;
   int          n_chk = 0, n_fail = 0;

   mips_lite_cpu dut (
      .clk(clk), .pc_reset(pc_reset), .pc_enable(pc_enable), .instr(instr),
      .data_out(data_out), .data_in(data_in), .inst_addr(inst_addr), .data_addr(data_addr),
      .mem_read_ctrlsig(mem_read_ctrlsig), .mem_write_ctrlsig(mem_write_ctrlsig)
`ifdef HALT_INSN_EN
      , .halted(halted)
`endif
   );

   always #5 clk = ~clk;
   assign instr    = mem[inst_addr[9:2]];
   assign data_out = mem[data_addr[9:2]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [5:0] fn, input logic [4:0] s, t, d, sh);
      return {6'h00, s, t, d, sh, fn};
   endfunction

   function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   task automatic put(input int k, input logic [31:0] w);
      mem[k] = w;
      mm[k]  = w;
   endtask

   // low half of memory holds code (zeroed), high half holds random data
   task automatic load();
      for (int k = 0; k < 256; k++) put(k, k >= 128 ? $urandom : 32'h0);
   endtask

   task automatic reset_core(input int n);
      pc_reset = 1'b1;
      #1;
      check("rst_pc", inst_addr, 32'h0);
      check("rst_we", 32'(mem_write_ctrlsig), 32'h0);
      check("rst_re", 32'(mem_read_ctrlsig), 32'h0);
      for (int r = 0; r < 32; r++) mr[r] = '0;
      mpc = '0;
      mhalt = 1'b0;
      repeat (n) @(negedge clk);
      pc_reset = 1'b0;
   endtask

   // one clock: compare DUT against the model before the edge, then retire both
   task automatic cycle(input bit en);
      logic [31:0] i, a, b, se, p4, res, nxt, ld_val;
      logic [4:0]  wr;
      bit          w, ld, st, hlt, dwe;
      logic [7:0]  dix;
      logic [31:0] dval;
      pc_enable = en;
      #1;
      i = mm[mpc[9:2]];
      a = mr[i[25:21]];
      b = mr[i[20:16]];
      se = {{16{i[15]}}, i[15:0]};
      p4 = mpc + 32'd4;
      nxt = p4; res = '0; wr = i[20:16]; w = 0; ld = 0; st = 0; hlt = 0;
      case (i[31:26])
         6'h00: begin
            wr = i[15:11];
            w = 1;
            case (i[5:0])
               6'h20, 6'h21: res = a + b;
               6'h22, 6'h23: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h27: res = ~(a | b);
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: res = (a < b) ? 32'd1 : 32'd0;
               6'h00: res = b << i[10:6];
               6'h02: res = b >> i[10:6];
               6'h03: res = $signed(b) >>> i[10:6];
               6'h08: begin w = 0; nxt = a; end
               default: w = 0;
            endcase
         end
         6'h08, 6'h09: begin res = a + se; w = 1; end
         6'h0A: begin res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; w = 1; end
         6'h0C: begin res = a & {16'h0, i[15:0]}; w = 1; end
         6'h0D: begin res = a | {16'h0, i[15:0]}; w = 1; end
         6'h0E: begin res = a ^ {16'h0, i[15:0]}; w = 1; end
         6'h0F: begin res = {i[15:0], 16'h0}; w = 1; end
         6'h23: begin res = a + se; ld = 1; w = 1; end
         6'h2B: begin res = a + se; st = 1; end
         6'h04: if (a == b) nxt = p4 + (se << 2);
         6'h05: if (a != b) nxt = p4 + (se << 2);
         6'h02: nxt = {p4[31:28], i[25:0], 2'b00};
         6'h03: begin nxt = {p4[31:28], i[25:0], 2'b00}; res = p4; wr = 5'd31; w = 1; end
         default: ;
      endcase
`ifdef HALT_INSN_EN
      if (mhalt || i == 32'hFC00_0000) begin
         w = 0; ld = 0; st = 0; hlt = 1; nxt = mpc;
      end
      check("halted", 32'(halted), 32'(hlt));
`endif
      check("pc", inst_addr, mpc);
      check("mem_we", 32'(mem_write_ctrlsig), 32'(en & st));
      if (en) check("mem_re", 32'(mem_read_ctrlsig), 32'(ld));
      if (ld || st) check("daddr", data_addr, res);
      if (st) check("din", data_in, b);
      dwe = mem_write_ctrlsig;
      dix = data_addr[9:2];
      dval = data_in;
      if (en) begin
         ld_val = mm[res[9:2]];
         if (st) mm[res[9:2]] = b;
         if (w && wr != 5'd0) mr[wr] = ld ? ld_val : res;
         mpc = nxt;
         mhalt = mhalt | hlt;
      end
      @(posedge clk);
      if (dwe) mem[dix] = dval;
      @(negedge clk);
   endtask

   logic [5:0] rfn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
   logic [5:0] iop [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

   function automatic logic [4:0] rreg();
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      // reset held 50 ns, then the ALU program with sltu
      load();
      put(0, ii(6'h2B, 0, 0, 16'h0200));
      put(1, ii(6'h08, 0, 1, 16'd5));
      put(2, ii(6'h08, 0, 2, 16'hFFFD));
      put(3, rr(6'h20, 1, 2, 3, 0));
      put(4, rr(6'h2A, 2, 1, 4, 0));
      put(5, rr(6'h2B, 2, 1, 6, 0));
      put(6, ii(6'h2B, 0, 3, 16'h0300));
      put(7, ii(6'h2B, 0, 4, 16'h0304));
      put(8, ii(6'h2B, 0, 6, 16'h0308));
      reset_core(5);
      for (int k = 0; k < 9; k++) begin
         check("seq", inst_addr, 32'(4 * k));
         cycle(1);
      end
      check("add_r3", mem[192], 32'd2);
      check("slt_r4", mem[193], 32'd1);
      check("sltu_r4", mem[194], 32'd0);

      // store then load through a base register
      load();
      put(0, ii(6'h08, 0, 1, 16'h0040));
      put(1, ii(6'h0D, 0, 2, 16'hBEEF));
      put(2, ii(6'h2B, 1, 2, 16'd4));
      put(3, ii(6'h23, 1, 5, 16'd4));
      put(4, ii(6'h2B, 0, 5, 16'h0300));
      reset_core(2);
      cycle(1); cycle(1);
      check("sw_addr", data_addr, 32'h44);
      check("sw_data", data_in, 32'hBEEF);
      check("sw_we", 32'(mem_write_ctrlsig), 32'd1);
      cycle(1);
      check("lw_re", 32'(mem_read_ctrlsig), 32'd1);
      cycle(1); cycle(1);
      check("lw_r5", mem[192], 32'hBEEF);

      // beq taken, jal, jr
      load();
      put(4, ii(6'h04, 0, 0, 16'd2));
      put(8, {6'h03, 26'h40});
      put(9, ii(6'h2B, 0, 31, 16'h0300));
      put(64, rr(6'h08, 31, 0, 0, 0));
      reset_core(2);
      repeat (5) cycle(1);
      check("beq", inst_addr, 32'h1C);
      repeat (2) cycle(1);
      check("jal", inst_addr, 32'h100);
      cycle(1);
      check("jr", inst_addr, 32'h24);
      cycle(1);
      check("jal_r31", mem[192], 32'h24);

      // bne with equal operands falls through
      load();
      put(4, ii(6'h05, 0, 0, 16'd2));
      reset_core(2);
      repeat (5) cycle(1);
      check("bne", inst_addr, 32'h14);

      // stall across a store, and r0 stays zero
      load();
      put(0, ii(6'h08, 0, 1, 16'd9));
      put(1, ii(6'h08, 0, 0, 16'd7));
      put(2, ii(6'h2B, 0, 1, 16'h0300));
      put(3, ii(6'h2B, 0, 0, 16'h0304));
      reset_core(2);
      cycle(1); cycle(1);
      v = mem[192];
      repeat (3) begin
         cycle(0);
         check("stall_pc", inst_addr, 32'h8);
         check("stall_we", 32'(mem_write_ctrlsig), 32'd0);
      end
      check("stall_mem", mem[192], v);
      cycle(1); cycle(1);
      check("st_r1", mem[192], 32'd9);
      check("r0_zero", mem[193], 32'd0);

      // reset during a store aborts it and clears registers
      load();
      put(0, ii(6'h2B, 0, 1, 16'h0304));
      put(1, ii(6'h08, 0, 1, 16'd9));
      put(2, ii(6'h2B, 0, 1, 16'h0300));
      reset_core(2);
      cycle(1); cycle(1);
      v = mem[192];
      pc_enable = 1'b1;
      reset_core(2);
      check("abort_mem", mem[192], v);
      check("rst_reg", data_in, 32'd0);
      cycle(1);

      // opcode 3F: HALT when enabled, otherwise a NOP
      load();
      put(2, 32'hFC00_0000);
      reset_core(2);
      repeat (5) cycle(1);
`ifdef HALT_INSN_EN
      check("halt_pc", inst_addr, 32'h8);
      check("halt_flag", 32'(halted), 32'd1);
      reset_core(2);
      check("halt_clr", 32'(halted), 32'd0);
      cycle(1);
`else
      check("nohalt_pc", inst_addr, 32'h14);
`endif

      // random programs with random stalls, registers dumped at the end
      for (int it = 0; it < 6; it++) begin
         int n;
         logic [31:0] fin;
         load();
         for (int k = 0; k < 40; k++)
            case ($urandom_range(0, 9))
               0, 1, 2: put(k, rr(rfn[$urandom_range(0, 12)], rreg(), rreg(), rreg(), rreg()));
               3, 4, 5: put(k, ii(iop[$urandom_range(0, 6)], rreg(), rreg(), 16'($urandom)));
               6: put(k, ii(6'h2B, 0, rreg(), 16'(32'h200 + $urandom_range(0, 255))));
               7: put(k, ii(6'h23, 0, rreg(), 16'(32'h200 + $urandom_range(0, 255))));
               8: put(k, ii(6'($urandom_range(4, 5)), rreg(), rreg(), 16'($urandom_range(0, 3))));
               default: put(k, $urandom_range(0, 1) != 0 ? rr(6'h01, rreg(), rreg(), rreg(), 0) : ii(6'h1F, rreg(), rreg(), 16'($urandom)));
            endcase
         for (int r = 1; r < 32; r++) put(39 + r, ii(6'h2B, 0, 5'(r), 16'(32'h300 + 4 * r)));
         fin = 32'(4 * 71);
         reset_core(2);
         n = 0;
         while (mpc < fin && n < 600) begin
            cycle($urandom_range(0, 4) != 0);
            n++;
         end
         if (n >= 600) check("timeout", mpc, fin);
         for (int r = 1; r < 32; r++) check("dump", mem[192 + r], mm[192 + r]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
